// File: rtl/pc_match_pkg.sv
// Shared defaults, table entry type and match helpers for the PC match pipeline.
// Entries are stored at XLEN_MAX width; narrower PCs are zero-extended before compare.
package pc_match_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int ENTRIES_DEF   = 32;
    localparam int PER_STAGE_DEF = 8;
    localparam int CNTW_DEF      = 16;
    localparam int XLEN_MAX      = 64;

    typedef logic [XLEN_MAX-1:0] word_t;

    typedef struct packed {
        word_t addr;
        word_t mask;
        logic  act;
    } entry_t;

    localparam entry_t ENTRY_RST = '{addr: '0, mask: '1, act: 1'b0};

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Masked equality: a mask bit of 1 means the bit takes part in the compare.
    function automatic logic entry_hit(input entry_t e, input word_t pc);
        return e.act && (((pc ^ e.addr) & e.mask) == '0);
    endfunction

endpackage

// File: rtl/pc_match_pipe_if.sv
// PC request / match result stream of pc_match_pipe; master issues PCs, slave returns results.
interface pc_match_pipe_if #(
    parameter int XLEN    = pc_match_pkg::XLEN_DEF,
    parameter int ENTRIES = pc_match_pkg::ENTRIES_DEF
);
    localparam int IW = pc_match_pkg::idx_w(ENTRIES);

    logic [XLEN-1:0] pc;
    logic            valid;
    logic            o_valid;
    logic [XLEN-1:0] o_pc;
    logic            o_hit;
    logic [IW-1:0]   o_idx;

    modport master (
        output pc, valid,
        input  o_valid, o_pc, o_hit, o_idx
    );

    modport slave (
        input  pc, valid,
        output o_valid, o_pc, o_hit, o_idx
    );

endinterface

// File: rtl/pc_match_stage.sv
// One compare stage: checks PER_STAGE entries starting at BASE and registers the running result.
// A hit carried in from an earlier stage always wins over a local hit.
module pc_match_stage
    import pc_match_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int ENTRIES   = ENTRIES_DEF,
    parameter int PER_STAGE = PER_STAGE_DEF,
    parameter int BASE      = 0,
    localparam int IW       = idx_w(ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  entry_t [PER_STAGE-1:0]   ents,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic                     in_hit,
    input  logic [IW-1:0]            in_idx,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic                     out_hit,
    output logic [IW-1:0]            out_idx
);

    word_t                pc_ext;
    logic [PER_STAGE-1:0] hit_vec;
    logic                 local_hit;
    logic [IW-1:0]        local_idx;
    logic                 hit_next;
    logic [IW-1:0]        idx_next;

    logic                 valid_reg;
    logic [XLEN-1:0]      pc_reg;
    logic                 hit_reg;
    logic [IW-1:0]        idx_reg;

    assign pc_ext = word_t'(in_pc);

    generate
        for (genvar gi = 0; gi < PER_STAGE; gi++) begin : g_cmp
            assign hit_vec[gi] = entry_hit(ents[gi], pc_ext);
        end
    endgenerate

    always_comb begin
        local_hit = 1'b0;
        local_idx = '0;
        for (int i = 0; i < PER_STAGE; i++) begin
            if (hit_vec[i] && !local_hit) begin
                local_hit = 1'b1;
                local_idx = IW'(BASE + i);
            end
        end

        hit_next = in_valid && (in_hit || local_hit);
        idx_next = '0;
        if (in_valid) begin
            if (in_hit) begin
                idx_next = in_idx;
            end else if (local_hit) begin
                idx_next = local_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            hit_reg   <= 1'b0;
            idx_reg   <= '0;
        end else begin
            valid_reg <= in_valid;
            pc_reg    <= in_pc;
            hit_reg   <= hit_next;
            idx_reg   <= idx_next;
        end
    end

    assign out_valid = valid_reg;
    assign out_pc    = pc_reg;
    assign out_hit   = hit_reg;
    assign out_idx   = idx_reg;

endmodule

// File: rtl/pc_match_pipe.sv
// Pipelined masked PC matcher: input register, ENTRIES/PER_STAGE compare stages, output register.
// Optional per-entry saturating hit counters are built when PC_MATCH_HITCNT_EN is defined.
module pc_match_pipe
    import pc_match_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int ENTRIES   = ENTRIES_DEF,
    parameter int PER_STAGE = PER_STAGE_DEF,
    parameter int CNTW      = CNTW_DEF,
    localparam int IW       = idx_w(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_match_pipe_if.slave   bus,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [XLEN-1:0]  wr_addr,
    input  logic [XLEN-1:0]  wr_mask,
    input  logic             wr_act,
    input  logic [IW-1:0]    rd_idx,
    output logic [CNTW-1:0]  rd_cnt
);

    // ENTRIES must be a multiple of PER_STAGE.
    localparam int STAGES = ENTRIES / PER_STAGE;

    entry_t [ENTRIES-1:0] tbl_reg;

    logic            in_valid_reg;
    logic [XLEN-1:0] in_pc_reg;

    logic            chain_valid [STAGES+1];
    logic [XLEN-1:0] chain_pc    [STAGES+1];
    logic            chain_hit   [STAGES+1];
    logic [IW-1:0]   chain_idx   [STAGES+1];

    logic            o_valid_reg;
    logic [XLEN-1:0] o_pc_reg;
    logic            o_hit_reg;
    logic [IW-1:0]   o_idx_reg;

    // Writes land at the sampling edge; every stage sees the new entry from the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_reg[i] <= ENTRY_RST;
            end
        end else if (wr_en) begin
            tbl_reg[wr_idx] <= '{addr: word_t'(wr_addr), mask: word_t'(wr_mask), act: wr_act};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_valid_reg <= 1'b0;
            in_pc_reg    <= '0;
        end else begin
            in_valid_reg <= bus.valid;
            in_pc_reg    <= bus.pc;
        end
    end

    assign chain_valid[0] = in_valid_reg;
    assign chain_pc[0]    = in_pc_reg;
    assign chain_hit[0]   = 1'b0;
    assign chain_idx[0]   = '0;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            pc_match_stage #(
                .XLEN      (XLEN),
                .ENTRIES   (ENTRIES),
                .PER_STAGE (PER_STAGE),
                .BASE      (gi * PER_STAGE)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .ents      (tbl_reg[gi*PER_STAGE +: PER_STAGE]),
                .in_valid  (chain_valid[gi]),
                .in_pc     (chain_pc[gi]),
                .in_hit    (chain_hit[gi]),
                .in_idx    (chain_idx[gi]),
                .out_valid (chain_valid[gi+1]),
                .out_pc    (chain_pc[gi+1]),
                .out_hit   (chain_hit[gi+1]),
                .out_idx   (chain_idx[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid_reg <= 1'b0;
            o_pc_reg    <= '0;
            o_hit_reg   <= 1'b0;
            o_idx_reg   <= '0;
        end else begin
            o_valid_reg <= chain_valid[STAGES];
            o_pc_reg    <= chain_pc[STAGES];
            o_hit_reg   <= chain_valid[STAGES] && chain_hit[STAGES];
            o_idx_reg   <= (chain_valid[STAGES] && chain_hit[STAGES]) ? chain_idx[STAGES] : '0;
        end
    end

    assign bus.o_valid = o_valid_reg;
    assign bus.o_pc    = o_pc_reg;
    assign bus.o_hit   = o_hit_reg;
    assign bus.o_idx   = o_idx_reg;

`ifdef PC_MATCH_HITCNT_EN
    logic [CNTW-1:0] cnt_reg [ENTRIES];
    logic [CNTW-1:0] rd_cnt_reg;

    // A table write to an entry restarts its count, even if that entry hits the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_reg[i] <= '0;
            end
            rd_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wr_en && (wr_idx == IW'(i))) begin
                    cnt_reg[i] <= '0;
                end else if (o_valid_reg && o_hit_reg && (o_idx_reg == IW'(i))
                             && (cnt_reg[i] != '1)) begin
                    cnt_reg[i] <= cnt_reg[i] + CNTW'(1);
                end
            end
            rd_cnt_reg <= cnt_reg[rd_idx];
        end
    end

    assign rd_cnt = rd_cnt_reg;
`else
    logic rd_idx_unused;
    assign rd_idx_unused = ^rd_idx;
    assign rd_cnt        = '0;
`endif

endmodule

// File: tb/tb_pc_match_pipe.sv
// Directed scoreboard bench for pc_match_pipe; hit-counter checks follow PC_MATCH_HITCNT_EN.
module tb_pc_match_pipe;
    import pc_match_pkg::*;

    localparam int XLEN      = 32;
    localparam int ENTRIES   = 32;
    localparam int PER_STAGE = 8;
    localparam int STAGES    = ENTRIES / PER_STAGE;
    localparam int LAT       = STAGES + 2;
`ifdef PC_MATCH_HITCNT_EN
    localparam int CNTW      = 4;
    localparam int SAT_EXP   = 15;
`else
    localparam int CNTW      = 16;
    localparam int SAT_EXP   = 0;
`endif
    localparam int IW        = idx_w(ENTRIES);
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en, wr_act;
    logic [IW-1:0]   wr_idx, rd_idx;
    logic [XLEN-1:0] wr_addr, wr_mask;
    logic [CNTW-1:0] rd_cnt;

    always #5 clk = ~clk;

    pc_match_pipe_if #(.XLEN(XLEN), .ENTRIES(ENTRIES)) bus ();

    pc_match_pipe #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .PER_STAGE(PER_STAGE), .CNTW(CNTW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_addr (wr_addr),
        .wr_mask (wr_mask),
        .wr_act  (wr_act),
        .rd_idx  (rd_idx),
        .rd_cnt  (rd_cnt)
    );

    typedef struct {
        logic [XLEN-1:0] pc;
        logic            hit;
        logic [IW-1:0]   idx;
        int              due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per presented result, checks idle outputs otherwise.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got o_valid=1 o_pc=0x%0h, expected o_valid=0", bus.o_pc);
            end else begin
                mon_e = sbq.pop_front();
                $display("txn pc=0x%08h hit=%0b idx=%0d cycle=%0d", bus.o_pc, bus.o_hit, bus.o_idx, cyc);
                check("o_pc", 64'(bus.o_pc), 64'(mon_e.pc));
                check("o_hit", 64'(bus.o_hit), 64'(mon_e.hit));
                check("o_idx", 64'(bus.o_idx), 64'(mon_e.idx));
                check("latency", 64'(cyc), 64'(mon_e.due));
            end
        end else begin
            check("idle_o_hit", 64'(bus.o_hit), 64'd0);
            check("idle_o_idx", 64'(bus.o_idx), 64'd0);
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                mon_e = sbq.pop_front();
                total++;
                bad++;
                $display("FAIL missing_result: pc=0x%0h got no o_valid, expected it at cycle %0d", mon_e.pc, mon_e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [XLEN-1:0] pc, input logic hit, input logic [IW-1:0] idx);
        bus.valid = 1'b1;
        bus.pc    = pc;
        sbq.push_back('{pc: pc, hit: hit, idx: idx, due: cyc + LAT});
        tick();
        bus.valid = 1'b0;
        bus.pc    = '0;
    endtask

    task automatic send_lost(input logic [XLEN-1:0] pc);
        bus.valid = 1'b1;
        bus.pc    = pc;
        tick();
        bus.valid = 1'b0;
        bus.pc    = '0;
    endtask

    task automatic write(input int idx, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] mask, input logic act);
        wr_en   = 1'b1;
        wr_idx  = IW'(idx);
        wr_addr = addr;
        wr_mask = mask;
        wr_act  = act;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() > 0; i++) tick();
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
            sbq.delete();
        end
        repeat (2) tick();
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.pc    = '0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_addr   = '0;
        wr_mask   = '0;
        wr_act    = 1'b0;
        rd_idx    = IW'(5);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_o_valid", 64'(bus.o_valid), 64'd0);
        check("rst_o_hit", 64'(bus.o_hit), 64'd0);
        check("rst_o_idx", 64'(bus.o_idx), 64'd0);
        check("rst_o_pc", 64'(bus.o_pc), 64'd0);
        check("rst_rd_cnt", 64'(rd_cnt), 64'd0);

        // Basic exact match.
        write(3, 32'h30, ONES, 1'b1);
        send(32'h30, 1'b1, IW'(3));
        drain();

        // Cross-stage priority, then deactivation.
        write(2, 32'h100, ONES, 1'b1);
        write(17, 32'h100, ONES, 1'b1);
        send(32'h100, 1'b1, IW'(2));
        write(2, 32'h100, ONES, 1'b0);
        send(32'h100, 1'b1, IW'(17));
        drain();

        // Partial mask.
        write(9, 32'h2000, 32'hFFFF_F000, 1'b1);
        send(32'h2ABC, 1'b1, IW'(9));
        send(32'h3000, 1'b0, IW'(0));
        drain();

        // Back-to-back issue, then gaps where pc toggles with valid low.
        send(32'h10, 1'b0, IW'(0));
        send(32'h20, 1'b0, IW'(0));
        send(32'h30, 1'b1, IW'(3));
        bus.pc = 32'h30;
        repeat (2) tick();
        bus.pc = '0;
        send(32'h30, 1'b1, IW'(3));
        drain();

        // A write one cycle after a pc does not re-evaluate that pc.
        send(32'h40, 1'b0, IW'(0));
        write(4, 32'h40, ONES, 1'b1);
        send(32'h40, 1'b1, IW'(4));
        drain();

        // mask=0 matches everything; lower index in the same stage and earlier stages win.
        write(10, 32'h0, 32'h0, 1'b1);
        send(32'h2ABC, 1'b1, IW'(9));
        send(32'h3000, 1'b1, IW'(10));
        send(32'h30, 1'b1, IW'(3));
        send(32'h100, 1'b1, IW'(10));
        drain();

        // Hit counter on entry 5: saturates at 15 with CNTW=4, clears on rewrite.
        write(5, 32'h50, ONES, 1'b1);
        for (int i = 0; i < 20; i++) send(32'h50, 1'b1, IW'(5));
        drain();
        check("rd_cnt_saturated", 64'(rd_cnt), 64'(SAT_EXP));
        write(5, 32'h50, ONES, 1'b1);
        tick();
        check("rd_cnt_after_rewrite", 64'(rd_cnt), 64'd0);

        // Reset with four pcs in flight and a simultaneous write that would match everything.
        send_lost(32'h30);
        send_lost(32'h50);
        send_lost(32'h2ABC);
        send_lost(32'h100);
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_idx  = IW'(0);
        wr_addr = 32'h0;
        wr_mask = 32'h0;
        wr_act  = 1'b1;
        tick();
        rst_n = 1'b1;
        wr_en = 1'b0;
        repeat (LAT + 2) tick();
        check("post_rst_rd_cnt", 64'(rd_cnt), 64'd0);
        send(32'h0, 1'b0, IW'(0));
        send(32'h30, 1'b0, IW'(0));
        send(32'h2ABC, 1'b0, IW'(0));
        send(32'h100, 1'b0, IW'(0));
        send(32'h50, 1'b0, IW'(0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
